mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-port memory.
// Each access is sampled only in IDLE. The winner gets a one-cycle grant in
// the same cycle as the memory strobe. Reads return rvalid one cycle later.
// A read takes 3 cycles (ACCESS, RESP, IDLE) and a write takes 2 (ACCESS, IDLE).
//
// Configuration macro:
//   MEM_ARBITER_RR_EN  defined   -> ties go to the requester that is not last_gnt
//                      undefined -> requester 0 always wins ties
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN, weN, addrN, wdataN requester N request / write-enable / address / data
//   gntN                     one-cycle grant pulse
//   rvalidN, rdataN          one-cycle read-data-valid pulse and read data
//   mem_we, mem_re           memory write / read strobes (ACCESS only)
//   mem_addr, mem_in         memory address and write data
//   mem_out                  registered memory read data (1 cycle after mem_re)
//   busy                     high whenever the FSM is not in IDLE
module mem_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e            state_q;
  logic              last_gnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              gnt0_q, gnt1_q;
  logic              rvalid0_q, rvalid1_q;
  logic              mem_we_q, mem_re_q;
  logic              busy_q;

  logic              win_d;
  logic              sel_we_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic [DATA_W-1:0] sel_wdata_d;

  // Winner selection and the winner's request fields
  always_comb begin
    win_d = 1'b0;
    if (req0 && req1) begin
`ifdef MEM_ARBITER_RR_EN
      win_d = ~last_gnt_q;
`else
      win_d = 1'b0;
`endif
    end else if (req1) begin
      win_d = 1'b1;
    end
    sel_we_d    = win_d ? we1    : we0;
    sel_addr_d  = win_d ? addr1  : addr0;
    sel_wdata_d = win_d ? wdata1 : wdata0;
  end

  // FSM with registered outputs; last_gnt_q also names the in-flight owner
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_re_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            state_q    <= ACCESS;
            busy_q     <= 1'b1;
            last_gnt_q <= win_d;
            addr_q     <= sel_addr_d;
            wdata_q    <= sel_wdata_d;
            gnt0_q     <= ~win_d;
            gnt1_q     <= win_d;
            mem_we_q   <= sel_we_d;
            mem_re_q   <= ~sel_we_d;
          end
        end
        ACCESS: begin
          // mem_we_q still holds the latched direction during ACCESS
          if (mem_we_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q   <= RESP;
            rvalid0_q <= ~last_gnt_q;
            rvalid1_q <= last_gnt_q;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign mem_we   = mem_we_q;
  assign mem_re   = mem_re_q;
  assign mem_addr = addr_q;
  assign mem_in   = wdata_q;
  assign busy     = busy_q;

  // Memory read data is already registered; both requesters see it directly
  assign rdata0 = mem_out;
  assign rdata1 = mem_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a cycle-scheduled
// expectation model, a bench-side memory, and literal spot checks.
module tb_mem_arbiter;
  localparam int unsigned AW   = 12;
  localparam int unsigned DW   = 8;
  localparam int unsigned MAXC = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_we, mem_re, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_in;
  logic [DW-1:0] mem_out = '0;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_in(mem_in),
    .mem_out(mem_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Bench-side memory: registered read, write at the strobe edge
  logic [DW-1:0] mem    [4096];
  logic [DW-1:0] shadow [4096];
  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]    = DW'(i) ^ 8'h5A;
      shadow[i] = DW'(i) ^ 8'h5A;
    end
  end
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_in;
    if (mem_re) mem_out <= mem[mem_addr];
  end

  // Expectation model: interval k is the time after rising edge k.
  // A request accepted at edge k gives gnt/strobe/busy in interval k,
  // and for a read rvalid/busy in interval k+1; sampling resumes at
  // edge k+2 (write) or k+3 (read).
  bit            e_gnt0 [MAXC];
  bit            e_gnt1 [MAXC];
  bit            e_rv0  [MAXC];
  bit            e_rv1  [MAXC];
  bit            e_we   [MAXC];
  bit            e_re   [MAXC];
  bit            e_busy [MAXC];
  logic [AW-1:0] e_addr [MAXC];
  logic [DW-1:0] e_din  [MAXC];
  logic [DW-1:0] e_rdata[MAXC];
  int            edge_n  = 0;
  int            free_at = 0;
  bit            m_last  = 1'b1;

  int            mk;
  bit            mw, mwe;
  logic [AW-1:0] ma;
  logic [DW-1:0] md;
  always @(posedge clk) begin
    edge_n = edge_n + 1;
    mk = edge_n;
    if (mk + 2 < MAXC) begin
      if (rst) begin
        for (int j = 0; j < 3; j++) begin
          e_gnt0[mk+j] = 0; e_gnt1[mk+j] = 0; e_rv0[mk+j] = 0; e_rv1[mk+j] = 0;
          e_we[mk+j] = 0; e_re[mk+j] = 0; e_busy[mk+j] = 0;
        end
        free_at = mk + 1;
        m_last  = 1'b1;
      end else if (mk >= free_at && (req0 || req1)) begin
        if (req0 && req1) begin
`ifdef MEM_ARBITER_RR_EN
          mw = ~m_last;
`else
          mw = 1'b0;
`endif
        end else begin
          mw = req1;
        end
        m_last = mw;
        mwe = mw ? we1 : we0;
        ma  = mw ? addr1 : addr0;
        md  = mw ? wdata1 : wdata0;
        if (mw) e_gnt1[mk] = 1; else e_gnt0[mk] = 1;
        e_we[mk] = mwe; e_re[mk] = !mwe; e_busy[mk] = 1;
        e_addr[mk] = ma; e_din[mk] = md;
        if (mwe) begin
          shadow[ma] = md;
          free_at = mk + 2;
        end else begin
          if (mw) e_rv1[mk+1] = 1; else e_rv0[mk+1] = 1;
          e_rdata[mk+1] = shadow[ma];
          e_busy[mk+1]  = 1;
          free_at = mk + 3;
        end
      end
    end
  end

  // Per-cycle compare against the model plus mutual-exclusion invariants
  int ck;
  always @(negedge clk) begin
    ck = edge_n;
    if (ck > 0 && ck < MAXC) begin
      chk("gnt0", 32'(gnt0), 32'(e_gnt0[ck]));
      chk("gnt1", 32'(gnt1), 32'(e_gnt1[ck]));
      chk("rvalid0", 32'(rvalid0), 32'(e_rv0[ck]));
      chk("rvalid1", 32'(rvalid1), 32'(e_rv1[ck]));
      chk("mem_we", 32'(mem_we), 32'(e_we[ck]));
      chk("mem_re", 32'(mem_re), 32'(e_re[ck]));
      chk("busy", 32'(busy), 32'(e_busy[ck]));
      if (e_we[ck] || e_re[ck]) chk("mem_addr", 32'(mem_addr), 32'(e_addr[ck]));
      if (e_we[ck]) chk("mem_in", 32'(mem_in), 32'(e_din[ck]));
      if (e_rv0[ck]) chk("rdata0", 32'(rdata0), 32'(e_rdata[ck]));
      if (e_rv1[ck]) chk("rdata1", 32'(rdata1), 32'(e_rdata[ck]));
      chk("we_and_re", 32'(mem_we & mem_re), 32'd0);
      chk("gnt_both", 32'(gnt0 & gnt1), 32'd0);
      chk("rvalid_both", 32'(rvalid0 & rvalid1), 32'd0);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Holds a request until granted, then drops it and lets the access drain
  task automatic access(input int who, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    bit got;
    got = 1'b0;
    if (who == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    else          begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((who == 0 && gnt0) || (who == 1 && gnt1)) got = 1'b1;
    end
    req0 = 0; req1 = 0;
    chk("grant_timeout", 32'(got), 32'd1);
  endtask

  int grants[$];
  bit seen;
  typedef struct { int who; bit we; logic [AW-1:0] a; logic [DW-1:0] d; } vec_t;
  vec_t vecs[6];

  initial begin
    rst = 1; req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    repeat (2) @(negedge clk);
    chk("reset_gnt0", 32'(gnt0), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    rst = 0;
    @(negedge clk);

    // Read 0x405 by requester 0
    req0 = 1; we0 = 0; addr0 = 12'h405;
    @(negedge clk);
    chk("t1_gnt0", 32'(gnt0), 32'd1);
    chk("t1_mem_re", 32'(mem_re), 32'd1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h405);
    req0 = 0;
    @(negedge clk);
    chk("t1_rvalid0", 32'(rvalid0), 32'd1);
    chk("t1_rdata0", 32'(rdata0), 32'h5F);
    @(negedge clk);
    chk("t1_busy_low", 32'(busy), 32'd0);

    // Write 0xA5 to 0xC00 by requester 1, then read it back
    req1 = 1; we1 = 1; addr1 = 12'hC00; wdata1 = 8'hA5;
    @(negedge clk);
    chk("t2_gnt1", 32'(gnt1), 32'd1);
    chk("t2_mem_we", 32'(mem_we), 32'd1);
    chk("t2_mem_in", 32'(mem_in), 32'hA5);
    chk("t2_mem_addr", 32'(mem_addr), 32'hC00);
    req1 = 0;
    @(negedge clk);
    chk("t2_busy_low", 32'(busy), 32'd0);
    chk("t2_no_rvalid", 32'(rvalid1 | rvalid0), 32'd0);
    access(0, 0, 12'hC00, 8'h00);
    @(negedge clk);
    chk("t2_readback", 32'(rdata0), 32'hA5);
    @(negedge clk);

    // Both requesters held continuously (reads)
    do_reset();
    req0 = 1; we0 = 0; addr0 = 12'h100;
    req1 = 1; we1 = 0; addr1 = 12'h200;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gnt0) grants.push_back(0);
      if (gnt1) grants.push_back(1);
    end
    req0 = 0; req1 = 0;
    chk("t3_grant_count", 32'(grants.size()), 32'd4);
    if (grants.size() >= 4) begin
`ifdef MEM_ARBITER_RR_EN
      chk("t3_order0", 32'(grants[0]), 32'd0);
      chk("t3_order1", 32'(grants[1]), 32'd1);
      chk("t3_order2", 32'(grants[2]), 32'd0);
      chk("t3_order3", 32'(grants[3]), 32'd1);
`else
      chk("t3_order0", 32'(grants[0]), 32'd0);
      chk("t3_order1", 32'(grants[1]), 32'd0);
      chk("t3_order2", 32'(grants[2]), 32'd0);
`endif
    end
    repeat (3) @(negedge clk);

    // Inputs changed after the sample edge must not affect the access
    req0 = 1; we0 = 0; addr0 = 12'h010;
    @(negedge clk);
    addr0 = 12'h020; req0 = 0;
    chk("t4_addr_held", 32'(mem_addr), 32'h010);
    @(negedge clk);
    chk("t4_rdata0", 32'(rdata0), 32'h4A);
    @(negedge clk);
    req1 = 1; we1 = 1; addr1 = 12'h077; wdata1 = 8'h11;
    @(negedge clk);
    wdata1 = 8'h99; addr1 = 12'h078; req1 = 0;
    chk("t4_wdata_held", 32'(mem_in), 32'h11);
    repeat (2) @(negedge clk);

    // Reset beats a same-cycle request
    rst = 1; req1 = 1; we1 = 0; addr1 = 12'h300;
    @(negedge clk);
    req1 = 0; rst = 0;
    chk("t5_rst_prio_gnt", 32'(gnt1), 32'd0);
    chk("t5_rst_prio_busy", 32'(busy), 32'd0);

    // Reset during ACCESS aborts the read
    req0 = 1; we0 = 0; addr0 = 12'h033;
    @(negedge clk);
    req0 = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    chk("t5_abort_re", 32'(mem_re), 32'd0);
    chk("t5_abort_gnt", 32'(gnt0), 32'd0);
    chk("t5_abort_busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rvalid0 || rvalid1) seen = 1;
    end
    chk("t5_no_late_rvalid", 32'(seen), 32'd0);

    // Simultaneous write by 0 and read by 1 of the same address
    do_reset();
    req0 = 1; we0 = 1; addr0 = 12'h2AA; wdata0 = 8'h3C;
    req1 = 1; we1 = 0; addr1 = 12'h2AA;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gnt0) req0 = 0;
      if (gnt1) req1 = 0;
      if (rvalid1) begin
        seen = 1;
        chk("t6_rdata1", 32'(rdata1), 32'h3C);
      end
    end
    req0 = 0; req1 = 0;
    chk("t6_rvalid1_seen", 32'(seen), 32'd1);

    // Mixed directed sequence checked by the model
    vecs[0] = '{1, 1'b1, 12'h001, 8'hDE};
    vecs[1] = '{0, 1'b1, 12'hFFF, 8'h01};
    vecs[2] = '{1, 1'b0, 12'hFFF, 8'h00};
    vecs[3] = '{0, 1'b0, 12'h001, 8'h00};
    vecs[4] = '{1, 1'b0, 12'h800, 8'h00};
    vecs[5] = '{0, 1'b1, 12'h800, 8'h77};
    foreach (vecs[i]) begin
      access(vecs[i].who, vecs[i].we, vecs[i].a, vecs[i].d);
      repeat (3) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
